// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the FIR sequencing controller.
package fir_pkg;

   localparam int unsigned N_TAPS = 16;
   localparam int unsigned COEF_W = 12;
   localparam int unsigned DATA_W = 12;
   localparam int unsigned ADDR_W = $clog2(N_TAPS);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      READY,
      RUN,
      DRAIN
   } state_e;

endpackage

// File: rtl/edge_det.sv
// Registered rising-edge detector for a level input (board button or switch).
module edge_det (
   input  logic clk,
   input  logic rst,
   input  logic s_i,
   output logic rise_o
);

   logic s_q;
   logic s_qq;

   // Register the level once, then keep one cycle of history for the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_q  <= 1'b0;
         s_qq <= 1'b0;
      end else begin
         s_q  <= s_i;
         s_qq <= s_q;
      end
   end

   assign rise_o = s_q & ~s_qq;

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequencer for the 16-tap FIR: loads the coefficient bank by address, then
// schedules one shared multiply-accumulate pass over all taps per accepted sample.
module fir_seq_ctrl
   import fir_pkg::*;
#(
   parameter int unsigned MAC_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              carga_coef_i,
   input  logic              cambio_coef_i,
   input  logic [COEF_W-1:0] coef_in,
   input  logic              send_i,
   output logic              coef_we_o,
   output logic [ADDR_W-1:0] coef_addr_o,
   output logic [COEF_W-1:0] coef_wdata_o,
   output logic              fin_block_coef_o,
   output logic              coef_full_o,
   output logic              sample_we_o,
   output logic [ADDR_W-1:0] samp_addr_o,
   output logic              mac_clr_o,
   output logic              mac_en_o,
   output logic              dato_valid_o,
   output logic              busy_o,
   output logic              overrun_o
);

   localparam int unsigned LatW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(N_TAPS - 1);
   localparam logic [LatW-1:0] LastLat = LatW'(MAC_LAT - 1);

   logic carga_rise, cambio_rise, send_rise;

   edge_det u_carga_edge (
      .clk    (clk),
      .rst    (rst),
      .s_i    (carga_coef_i),
      .rise_o (carga_rise)
   );

   edge_det u_cambio_edge (
      .clk    (clk),
      .rst    (rst),
      .s_i    (cambio_coef_i),
      .rise_o (cambio_rise)
   );

   edge_det u_send_edge (
      .clk    (clk),
      .rst    (rst),
      .s_i    (send_i),
      .rise_o (send_rise)
   );

   state_e            st_q, st_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] k_q, k_d;
   logic [LatW-1:0]   lat_q, lat_d;
   logic              full_q, full_d;
   logic              ovr_q, ovr_d;
   logic              coef_we_q, coef_we_d;
   logic [ADDR_W-1:0] coef_addr_q, coef_addr_d;
   logic [COEF_W-1:0] coef_wdata_q;
   logic              fin_q, fin_d;
   logic              sample_we_q, sample_we_d;
   logic [ADDR_W-1:0] samp_addr_q, samp_addr_d;
   logic              mac_clr_q, mac_clr_d;
   logic              mac_en_q, mac_en_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;

   // Next-state and next-output decode; every output is registered below.
   always_comb begin
      st_d        = st_q;
      waddr_d     = waddr_q;
      wptr_d      = wptr_q;
      base_d      = base_q;
      k_d         = k_q;
      lat_d       = lat_q;
      full_d      = full_q;
      ovr_d       = ovr_q;
      coef_we_d   = 1'b0;
      coef_addr_d = '0;
      fin_d       = 1'b0;
      sample_we_d = 1'b0;
      samp_addr_d = '0;
      mac_clr_d   = 1'b0;
      mac_en_d    = 1'b0;
      valid_d     = 1'b0;

      unique case (st_q)
         IDLE, READY: begin
            if (carga_rise) begin
               st_d    = LOAD;
               waddr_d = '0;
               full_d  = 1'b0;
            end else if (send_rise && st_q == READY) begin
               sample_we_d = 1'b1;
               samp_addr_d = wptr_q;
               base_d      = wptr_q;
               wptr_d      = wptr_q + 1'b1;
               k_d         = '0;
               st_d        = RUN;
            end
         end
         LOAD: begin
            // A restart beats a simultaneous write strobe.
            if (carga_rise) begin
               waddr_d = '0;
               full_d  = 1'b0;
            end else if (cambio_rise) begin
               coef_we_d   = 1'b1;
               coef_addr_d = waddr_q;
               waddr_d     = waddr_q + 1'b1;
               if (waddr_q == LastAddr) begin
                  fin_d  = 1'b1;
                  full_d = 1'b1;
                  st_d   = READY;
               end
            end
         end
         RUN: begin
            mac_en_d    = 1'b1;
            mac_clr_d   = (k_q == '0);
            coef_addr_d = k_q;
            samp_addr_d = base_q - k_q;  // newest sample pairs with tap 0
            k_d         = k_q + 1'b1;
            if (k_q == LastAddr) begin
               lat_d = '0;
               st_d  = DRAIN;
            end
         end
         DRAIN: begin
            if (lat_q == LastLat) begin
               valid_d = 1'b1;
               st_d    = READY;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         default: st_d = IDLE;
      endcase

      if (send_rise && (st_q == RUN || st_q == DRAIN)) begin
         ovr_d = 1'b1;
      end

      busy_d = (st_d == RUN) || (st_d == DRAIN);
   end

   // State, counters and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q         <= IDLE;
         waddr_q      <= '0;
         wptr_q       <= '0;
         base_q       <= '0;
         k_q          <= '0;
         lat_q        <= '0;
         full_q       <= 1'b0;
         ovr_q        <= 1'b0;
         coef_we_q    <= 1'b0;
         coef_addr_q  <= '0;
         coef_wdata_q <= '0;
         fin_q        <= 1'b0;
         sample_we_q  <= 1'b0;
         samp_addr_q  <= '0;
         mac_clr_q    <= 1'b0;
         mac_en_q     <= 1'b0;
         valid_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         st_q         <= st_d;
         waddr_q      <= waddr_d;
         wptr_q       <= wptr_d;
         base_q       <= base_d;
         k_q          <= k_d;
         lat_q        <= lat_d;
         full_q       <= full_d;
         ovr_q        <= ovr_d;
         coef_we_q    <= coef_we_d;
         coef_addr_q  <= coef_addr_d;
         coef_wdata_q <= coef_in;
         fin_q        <= fin_d;
         sample_we_q  <= sample_we_d;
         samp_addr_q  <= samp_addr_d;
         mac_clr_q    <= mac_clr_d;
         mac_en_q     <= mac_en_d;
         valid_q      <= valid_d;
         busy_q       <= busy_d;
      end
   end

   assign coef_we_o        = coef_we_q;
   assign coef_addr_o      = coef_addr_q;
   assign coef_wdata_o     = coef_wdata_q;
   assign fin_block_coef_o = fin_q;
   assign coef_full_o      = full_q;
   assign sample_we_o      = sample_we_q;
   assign samp_addr_o      = samp_addr_q;
   assign mac_clr_o        = mac_clr_q;
   assign mac_en_o         = mac_en_q;
   assign dato_valid_o     = valid_q;
   assign busy_o           = busy_q;
   assign overrun_o        = ovr_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl: table-driven coefficient loads, scoreboard of expected
// output events, and hand-written overrun / restart / reset sequences.
module tb_fir_seq_ctrl;
   import fir_pkg::*;

   localparam int NT     = N_TAPS;
   localparam int MacLat = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              carga = 1'b0;
   logic              cambio = 1'b0;
   logic              send = 1'b0;
   logic [COEF_W-1:0] coef_in = '0;

   logic              coef_we_o, fin_block_coef_o, coef_full_o, sample_we_o;
   logic              mac_clr_o, mac_en_o, dato_valid_o, busy_o, overrun_o;
   logic [ADDR_W-1:0] coef_addr_o, samp_addr_o;
   logic [COEF_W-1:0] coef_wdata_o;

   fir_seq_ctrl #(.MAC_LAT(MacLat)) dut (
      .clk              (clk),
      .rst              (rst),
      .carga_coef_i     (carga),
      .cambio_coef_i    (cambio),
      .coef_in          (coef_in),
      .send_i           (send),
      .coef_we_o        (coef_we_o),
      .coef_addr_o      (coef_addr_o),
      .coef_wdata_o     (coef_wdata_o),
      .fin_block_coef_o (fin_block_coef_o),
      .coef_full_o      (coef_full_o),
      .sample_we_o      (sample_we_o),
      .samp_addr_o      (samp_addr_o),
      .mac_clr_o        (mac_clr_o),
      .mac_en_o         (mac_en_o),
      .dato_valid_o     (dato_valid_o),
      .busy_o           (busy_o),
      .overrun_o        (overrun_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum int {EvWr, EvSmp, EvMac, EvVal} ev_e;
   typedef struct {
      ev_e kind;
      int  a;
      int  b;
      int  flag;
      int  data;
      int  cyc;
   } ev_t;

   typedef struct {
      logic [COEF_W-1:0] coef;
      int                addr;
      int                fin;
   } vec_t;

   ev_t  sbq[$];
   vec_t tbl[NT];
   int   n_chk  = 0;
   int   n_pass = 0;
   int   wptr_m = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic void push(input ev_e k, input int a, input int b, input int f,
                                input int dt, input int c);
      ev_t e;
      e.kind = k; e.a = a; e.b = b; e.flag = f; e.data = dt; e.cyc = c;
      sbq.push_back(e);
   endfunction

   task automatic observe(input ev_e k, input int a, input int b, input int f, input int dt);
      ev_t e;
      n_chk++;
      if (sbq.size() == 0) begin
         $display("FAIL unexpected_%s: seen at cycle %0d, required none", k.name(), cyc);
         return;
      end
      e = sbq.pop_front();
      if (e.kind == k && e.a == a && e.b == b && e.flag == f && e.data == dt && e.cyc == cyc)
         n_pass++;
      else
         $display("FAIL event: got %s a=%0d b=%0d flag=%0d data=%0d cyc=%0d, required %s a=%0d b=%0d flag=%0d data=%0d cyc=%0d",
                  k.name(), a, b, f, dt, cyc, e.kind.name(), e.a, e.b, e.flag, e.data, e.cyc);
   endtask

   // Output monitor: every strobe must match the head of the scoreboard.
   always @(negedge clk) begin
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
         n_chk++;
         $display("FAIL missing_%s: not seen by cycle %0d, required at cycle %0d",
                  sbq[0].kind.name(), cyc, sbq[0].cyc);
         void'(sbq.pop_front());
      end
      if (coef_we_o)
         observe(EvWr, int'(coef_addr_o), 0, int'(fin_block_coef_o), int'(coef_wdata_o));
      else if (fin_block_coef_o)
         chk("stray_fin", 1, 0);
      if (sample_we_o) observe(EvSmp, 0, int'(samp_addr_o), 0, 0);
      if (mac_en_o)
         observe(EvMac, int'(coef_addr_o), int'(samp_addr_o), int'(mac_clr_o), 0);
      else if (mac_clr_o)
         chk("stray_mac_clr", 1, 0);
      if (dato_valid_o) observe(EvVal, 0, 0, 0, 0);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_coef_we"}, int'(coef_we_o), 0);
      chk({tag, "_coef_addr"}, int'(coef_addr_o), 0);
      chk({tag, "_coef_wdata"}, int'(coef_wdata_o), 0);
      chk({tag, "_fin"}, int'(fin_block_coef_o), 0);
      chk({tag, "_full"}, int'(coef_full_o), 0);
      chk({tag, "_sample_we"}, int'(sample_we_o), 0);
      chk({tag, "_samp_addr"}, int'(samp_addr_o), 0);
      chk({tag, "_mac_clr"}, int'(mac_clr_o), 0);
      chk({tag, "_mac_en"}, int'(mac_en_o), 0);
      chk({tag, "_valid"}, int'(dato_valid_o), 0);
      chk({tag, "_busy"}, int'(busy_o), 0);
      chk({tag, "_overrun"}, int'(overrun_o), 0);
   endtask

   task automatic pulse_carga();
      carga = 1'b1;
      tick(1);
      carga = 1'b0;
      tick(3);
   endtask

   task automatic pulse_send_ignored();
      send = 1'b1;
      tick(1);
      send = 1'b0;
      tick(4);
   endtask

   // Write the first n table entries; each write appears two cycles after driving.
   task automatic load(input int n);
      for (int i = 0; i < n; i++) begin
         coef_in = tbl[i].coef;
         cambio  = 1'b1;
         push(EvWr, tbl[i].addr, 0, tbl[i].fin, int'(tbl[i].coef), cyc + 2);
         tick(1);
         cambio = 1'b0;
         tick(2);
      end
   endtask

   // Send a sample; expect taps 0..last_k, and the result strobe for a full pass.
   task automatic do_send(input int last_k);
      int d;
      d = cyc;
      send = 1'b1;
      push(EvSmp, 0, wptr_m, 0, 0, d + 2);
      for (int k = 0; k <= last_k; k++)
         push(EvMac, k, (wptr_m - k) & (NT - 1), (k == 0) ? 1 : 0, 0, d + 3 + k);
      if (last_k == NT - 1) push(EvVal, 0, 0, 0, 0, d + 2 + NT + MacLat);
      wptr_m = (wptr_m + 1) % NT;
      tick(1);
      send = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int coefs[NT] = '{-99, 65, 136, 33, -156, -86, 376, 854,
                        854, 376, -86, -156, 33, 136, 65, -99};
      int d0;
      for (int i = 0; i < NT; i++) begin
         tbl[i].coef = COEF_W'(coefs[i]);
         tbl[i].addr = i;
         tbl[i].fin  = (i == NT - 1) ? 1 : 0;
      end

      tick(3);
      check_zero("reset");
      rst = 1'b0;
      tick(2);

      // Send before any coefficients: silently ignored.
      pulse_send_ignored();
      chk("idle_send_overrun", int'(overrun_o), 0);

      pulse_carga();
      chk("full_after_carga", int'(coef_full_o), 0);
      load(NT);
      tick(1);
      chk("full_after_load", int'(coef_full_o), 1);
      chk("busy_ready", int'(busy_o), 0);

      // First send, a dropped send at E+5, then a send at the minimum period.
      d0 = cyc;
      do_send(NT - 1);
      tick(4);
      send = 1'b1;
      tick(1);
      send = 1'b0;
      tick(2);
      chk("busy_run", int'(busy_o), 1);
      chk("overrun_set", int'(overrun_o), 1);
      tick(d0 + 19 - cyc);
      do_send(NT - 1);
      tick(20);
      chk("busy_after_runs", int'(busy_o), 0);
      chk("overrun_held", int'(overrun_o), 1);

      // Restart after a partial load, and carga racing cambio.
      pulse_carga();
      chk("full_cleared_by_carga", int'(coef_full_o), 0);
      load(7);
      pulse_carga();
      load(3);
      carga   = 1'b1;
      cambio  = 1'b1;
      coef_in = COEF_W'(1445);
      tick(1);
      carga  = 1'b0;
      cambio = 1'b0;
      tick(3);
      load(NT);
      tick(1);
      chk("full_after_reload", int'(coef_full_o), 1);

      // Reset while the pass is at tap 8.
      do_send(8);
      tick(10);
      rst = 1'b1;
      tick(1);
      check_zero("mid_run_reset");
      tick(1);
      rst = 1'b0;
      wptr_m = 0;
      tick(2);

      pulse_send_ignored();
      chk("full_after_reset", int'(coef_full_o), 0);
      pulse_carga();
      pulse_send_ignored();
      chk("load_send_overrun", int'(overrun_o), 0);
      load(NT);
      tick(1);
      do_send(NT - 1);
      tick(25);
      chk("final_overrun", int'(overrun_o), 0);
      chk("scoreboard_drained", sbq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
